// File: rtl/function_generator_seq_pkg.sv
// Shared constants, default base vectors and FSM state type for the row generator.
// Optional feature macro: FGEN_LOAD_EN (writable base table with load port).
package fgen_pkg;

    localparam int FGEN_K_N      = 256;
    localparam int FGEN_NUM_BASE = 4;
    localparam int FGEN_ROWS     = 16;
    localparam int FGEN_ROT_STEP = 16;

    localparam logic [FGEN_K_N-1:0] FGEN_BASE_DEFAULT [FGEN_NUM_BASE] = '{
        256'hA46E4D428785B1F9D8B4E21F29CBC29BAEA864941632C25D592CF718233853E4,
        256'hCDE507D9D76A4E862DD0B259985C5C7F79BC655F18914CA6AC5D996B07F67B32,
        256'h8CC55DD293683704607D5B56B65BC01B82B9133F1708DEA7280FFC336042EDB2,
        256'hA03BA4371527756650C054E5086DF88DEF5B2EBBA6AB6F46ED7572AA3675EFA8
    };

    typedef enum logic [0:0] {
        FGEN_IDLE = 1'b0,
        FGEN_RUN  = 1'b1
    } fgen_state_t;

endpackage

// File: rtl/function_generator_seq_if.sv
// Request / row-stream bundle between encoder control, generator and datapath.
// With FGEN_LOAD_EN the bundle also carries the base-table load port.
interface function_generator_seq_if #(
    parameter int K_N      = 256,
    parameter int NUM_BASE = 4,
    parameter int ROWS     = 16
);
    localparam int SEL_W = $clog2(NUM_BASE);
    localparam int IDX_W = $clog2(ROWS);

    logic             start;
    logic [SEL_W-1:0] sel;
    logic [K_N-1:0]   f;
    logic             f_valid;
    logic             f_ready;
    logic             f_last;
    logic [IDX_W-1:0] row_idx;
    logic             busy;
`ifdef FGEN_LOAD_EN
    logic             ld_en;
    logic [SEL_W-1:0] ld_addr;
    logic [K_N-1:0]   ld_data;
    logic             ld_drop;

    modport master (output start, sel, f_ready, ld_en, ld_addr, ld_data,
                    input  f, f_valid, f_last, row_idx, busy, ld_drop);
    modport slave  (input  start, sel, f_ready, ld_en, ld_addr, ld_data,
                    output f, f_valid, f_last, row_idx, busy, ld_drop);
`else
    modport master (output start, sel, f_ready,
                    input  f, f_valid, f_last, row_idx, busy);
    modport slave  (input  start, sel, f_ready,
                    output f, f_valid, f_last, row_idx, busy);
`endif

endinterface

// File: rtl/function_generator_seq_base_table.sv
// Base vector store: constant ROM by default, reset-initialised register array
// with a single write port when FGEN_LOAD_EN is defined.
module fgen_base_table
    import fgen_pkg::*;
#(
    parameter int K_N      = FGEN_K_N,
    parameter int NUM_BASE = FGEN_NUM_BASE,
    localparam int SEL_W   = $clog2(NUM_BASE)
) (
`ifdef FGEN_LOAD_EN
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_addr,
    input  logic [K_N-1:0]   wr_data,
`endif
    input  logic [SEL_W-1:0] rd_addr,
    output logic [K_N-1:0]   rd_data
);

    // Extra table slots beyond the package array reuse the defaults cyclically.
    function automatic logic [K_N-1:0] base_default(input int idx);
        return K_N'(FGEN_BASE_DEFAULT[idx % FGEN_NUM_BASE]);
    endfunction

`ifdef FGEN_LOAD_EN
    logic [K_N-1:0] table_r [NUM_BASE];

    // Writable table; reset restores the package defaults.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BASE; i++) begin
                table_r[i] <= base_default(i);
            end
        end else if (wr_en) begin
            table_r[wr_addr] <= wr_data;
        end else begin
            table_r <= table_r;
        end
    end

    assign rd_data = table_r[rd_addr];
`else
    logic [K_N-1:0] table_s [NUM_BASE];

    for (genvar g = 0; g < NUM_BASE; g++) begin : g_rom
        assign table_s[g] = base_default(g);
    end

    assign rd_data = table_s[rd_addr];
`endif

endmodule

// File: rtl/function_generator_seq.sv
// Streams the ROWS circulant rows of a selected base vector over a valid/ready
// handshake. Define FGEN_LOAD_EN to make the base table loadable at run time.
module function_generator_seq
    import fgen_pkg::*;
#(
    parameter int K_N      = FGEN_K_N,
    parameter int NUM_BASE = FGEN_NUM_BASE,
    parameter int ROWS     = FGEN_ROWS,
    parameter int ROT_STEP = FGEN_ROT_STEP
) (
    input  logic                      clk,
    input  logic                      rst,
    function_generator_seq_if.slave   bus
);

    localparam int              SEL_W = $clog2(NUM_BASE);
    localparam int              IDX_W = $clog2(ROWS);
    localparam int              ROT   = ROT_STEP % K_N;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(ROWS - 1);

    // One step of the circulant: each row is the previous one rotated right by ROT.
    function automatic logic [K_N-1:0] rotr(input logic [K_N-1:0] v);
        return (v >> ROT) | (v << (K_N - ROT));
    endfunction

    // The select field can only exceed NUM_BASE by less than NUM_BASE, so one subtract suffices.
    function automatic logic [SEL_W-1:0] mod_base(input logic [SEL_W-1:0] a);
        if ({1'b0, a} >= (SEL_W+1)'(NUM_BASE)) begin
            return a - SEL_W'(NUM_BASE);
        end else begin
            return a;
        end
    endfunction

    fgen_state_t      state_r, state_s;
    logic [K_N-1:0]   f_r, f_s;
    logic             f_valid_r, f_valid_s;
    logic [IDX_W-1:0] row_idx_r, row_idx_s;
    logic             busy_r, busy_s;
    logic [SEL_W-1:0] rd_addr_s;
    logic [K_N-1:0]   rd_data_s;
`ifdef FGEN_LOAD_EN
    logic             ld_drop_r, ld_drop_s;
    logic             wr_en_s;
    logic [SEL_W-1:0] wr_addr_s;
`endif

    assign rd_addr_s = mod_base(bus.sel);

`ifdef FGEN_LOAD_EN
    assign wr_addr_s = mod_base(bus.ld_addr);

    fgen_base_table #(.K_N(K_N), .NUM_BASE(NUM_BASE)) u_table (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr_s),
        .wr_data (bus.ld_data),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );
`else
    fgen_base_table #(.K_N(K_N), .NUM_BASE(NUM_BASE)) u_table (
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );
`endif

    // Next-state and next-output logic; everything holds unless a start or transfer happens.
    always_comb begin
        state_s   = state_r;
        f_s       = f_r;
        f_valid_s = f_valid_r;
        row_idx_s = row_idx_r;
        busy_s    = busy_r;
`ifdef FGEN_LOAD_EN
        wr_en_s   = bus.ld_en && (state_r == FGEN_IDLE) && !bus.start;
        ld_drop_s = bus.ld_en && !wr_en_s;
`endif
        case (state_r)
            FGEN_IDLE: begin
                if (bus.start) begin
                    state_s   = FGEN_RUN;
                    f_s       = rd_data_s;
                    row_idx_s = '0;
                    f_valid_s = 1'b1;
                    busy_s    = 1'b1;
                end else begin
                    state_s   = FGEN_IDLE;
                end
            end
            FGEN_RUN: begin
                if (f_valid_r && bus.f_ready) begin
                    if (row_idx_r == LAST) begin
                        state_s   = FGEN_IDLE;
                        f_s       = '0;
                        f_valid_s = 1'b0;
                        row_idx_s = '0;
                        busy_s    = 1'b0;
                    end else begin
                        f_s       = rotr(f_r);
                        row_idx_s = row_idx_r + IDX_W'(1);
                    end
                end else begin
                    state_s   = FGEN_RUN;
                end
            end
            default: begin
                state_s   = FGEN_IDLE;
                f_s       = '0;
                f_valid_s = 1'b0;
                row_idx_s = '0;
                busy_s    = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= FGEN_IDLE;
            f_r       <= '0;
            f_valid_r <= 1'b0;
            row_idx_r <= '0;
            busy_r    <= 1'b0;
`ifdef FGEN_LOAD_EN
            ld_drop_r <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            f_r       <= f_s;
            f_valid_r <= f_valid_s;
            row_idx_r <= row_idx_s;
            busy_r    <= busy_s;
`ifdef FGEN_LOAD_EN
            ld_drop_r <= ld_drop_s;
`endif
        end
    end

    assign bus.f       = f_r;
    assign bus.f_valid = f_valid_r;
    assign bus.row_idx = row_idx_r;
    assign bus.busy    = busy_r;
    assign bus.f_last  = f_valid_r && (row_idx_r == LAST);
`ifdef FGEN_LOAD_EN
    assign bus.ld_drop = ld_drop_r;
`endif

endmodule

// File: tb/tb_function_generator_seq.sv
// Directed bench for function_generator_seq with a burst-level reference model.
// Load-port scenarios run only when FGEN_LOAD_EN is defined.
module tb_function_generator_seq;

    localparam int K    = 256;
    localparam int NB   = 4;
    localparam int ROWS = 16;
    localparam int STEP = 16;

    localparam logic [K-1:0] B0   = 256'hA46E4D428785B1F9D8B4E21F29CBC29BAEA864941632C25D592CF718233853E4;
    localparam logic [K-1:0] B1   = 256'hCDE507D9D76A4E862DD0B259985C5C7F79BC655F18914CA6AC5D996B07F67B32;
    localparam logic [K-1:0] B2   = 256'h8CC55DD293683704607D5B56B65BC01B82B9133F1708DEA7280FFC336042EDB2;
    localparam logic [K-1:0] B3   = 256'hA03BA4371527756650C054E5086DF88DEF5B2EBBA6AB6F46ED7572AA3675EFA8;
    localparam logic [K-1:0] B0R1 = 256'h53E4A46E4D428785B1F9D8B4E21F29CBC29BAEA864941632C25D592CF7182338;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    function_generator_seq_if #(.K_N(K), .NUM_BASE(NB), .ROWS(ROWS)) bus ();

    function_generator_seq #(.K_N(K), .NUM_BASE(NB), .ROWS(ROWS), .ROT_STEP(STEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [K-1:0] act, input logic [K-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Right rotation by s bits, bit by bit.
    function automatic logic [K-1:0] rot_model(input logic [K-1:0] v, input int s);
        logic [K-1:0] r;
        for (int b = 0; b < K; b++) r[b] = v[(b + s) % K];
        return r;
    endfunction

    // Reference model: burst in progress, its row 0 and current row number.
    logic [K-1:0] tbl [NB];
    logic         m_active;
    logic [K-1:0] m_row0;
    int           m_j;
    logic         m_drop;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_j      <= 0;
            m_row0   <= '0;
            m_drop   <= 1'b0;
            tbl[0] <= B0; tbl[1] <= B1; tbl[2] <= B2; tbl[3] <= B3;
        end else begin
            m_drop <= 1'b0;
            if (m_active) begin
`ifdef FGEN_LOAD_EN
                if (bus.ld_en) m_drop <= 1'b1;
`endif
                if (bus.f_ready) begin
                    if (m_j == ROWS - 1) m_active <= 1'b0;
                    else m_j <= m_j + 1;
                end
            end else if (bus.start) begin
                m_active <= 1'b1;
                m_row0   <= tbl[int'(bus.sel) % NB];
                m_j      <= 0;
`ifdef FGEN_LOAD_EN
                if (bus.ld_en) m_drop <= 1'b1;
            end else if (bus.ld_en) begin
                tbl[int'(bus.ld_addr) % NB] <= bus.ld_data;
`endif
            end
        end
    end

    // Per-cycle compare against the model, plus transfers-per-burst count.
    int xfer = 0;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            chk("f", bus.f, m_active ? rot_model(m_row0, m_j * STEP) : '0);
            chk("f_valid", K'(bus.f_valid), K'(m_active));
            chk("busy", K'(bus.busy), K'(m_active));
            chk("f_last", K'(bus.f_last), K'(m_active && (m_j == ROWS - 1)));
            if (m_active) chk("row_idx", K'(bus.row_idx), K'(m_j));
`ifdef FGEN_LOAD_EN
            chk("ld_drop", K'(bus.ld_drop), K'(m_drop));
`endif
            if (rst) begin
                xfer = 0;
            end else if (bus.f_valid && bus.f_ready) begin
                xfer++;
                if (bus.f_last) begin
                    chk("burst_len", K'(xfer), K'(ROWS));
                    xfer = 0;
                end
            end
        end
    end

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (bus.busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", K'(bus.busy), '0);
    endtask

    int n;
    initial begin
        bus.start = 1'b0; bus.sel = '0; bus.f_ready = 1'b0;
`ifdef FGEN_LOAD_EN
        bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
`endif
        // Model pins.
        chk("model_row1", rot_model(B0, STEP), B0R1);
        chk("model_wrap", rot_model(B0, STEP * ROWS), B0);

        repeat (3) @(negedge clk);
        chk("rst_f", bus.f, '0);
        chk("rst_valid", K'(bus.f_valid), '0);
        chk("rst_busy", K'(bus.busy), '0);
        chk("rst_last", K'(bus.f_last), '0);
        chk("rst_idx", K'(bus.row_idx), '0);
        rst = 1'b0;

        // Base 0, consumer always ready.
        @(negedge clk); bus.start = 1'b1; bus.sel = 2'd0; bus.f_ready = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        chk("s1_row0", bus.f, B0);
        chk("s1_idx0", K'(bus.row_idx), '0);
        @(negedge clk);
        chk("s1_row1", bus.f, B0R1);
        wait_idle(100, n);
        chk("s1_cycles", K'(n), K'(15));

        // Base 3 with ready toggling every cycle.
        @(negedge clk); bus.start = 1'b1; bus.sel = 2'd3;
        @(negedge clk); bus.start = 1'b0;
        chk("s2_row0", bus.f, B3);
        for (int i = 0; i < 40; i++) begin
            bus.f_ready = ~bus.f_ready;
            @(negedge clk);
        end
        bus.f_ready = 1'b1;
        wait_idle(100, n);

        // Start held high: one burst, then one idle cycle, then the next.
        @(negedge clk); bus.start = 1'b1; bus.sel = 2'd2;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.f_last && n < 40);
        chk("s3_last_seen", K'(bus.f_last), K'(1));
        @(negedge clk);
        chk("s3_gap_valid", K'(bus.f_valid), '0);
        chk("s3_gap_busy", K'(bus.busy), '0);
        @(negedge clk);
        chk("s3_next_valid", K'(bus.f_valid), K'(1));
        chk("s3_next_row0", bus.f, B2);
        bus.start = 1'b0;
        wait_idle(100, n);

        // Reset in the middle of a burst.
        @(negedge clk); bus.start = 1'b1; bus.sel = 2'd0;
        @(negedge clk); bus.start = 1'b0;
        n = 0;
        while (bus.row_idx != 4'd7 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("s4_row7", K'(bus.row_idx), K'(7));
        rst = 1'b1;
        #1;
        chk("s4_rst_f", bus.f, '0);
        chk("s4_rst_valid", K'(bus.f_valid), '0);
        chk("s4_rst_busy", K'(bus.busy), '0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); bus.start = 1'b1; bus.sel = 2'd1;
        @(negedge clk); bus.start = 1'b0;
        chk("s4_sel1_row0", bus.f, B1);
        wait_idle(100, n);

`ifdef FGEN_LOAD_EN
        // Load base 2 with all ones, then try a dropped write during a burst.
        @(negedge clk); bus.ld_en = 1'b1; bus.ld_addr = 2'd2; bus.ld_data = '1;
        @(negedge clk); bus.ld_en = 1'b0;
        chk("s5_no_drop", K'(bus.ld_drop), '0);
        bus.start = 1'b1; bus.sel = 2'd2;
        @(negedge clk); bus.start = 1'b0;
        chk("s5_ones_row0", bus.f, '1);
        bus.ld_en = 1'b1; bus.ld_data = '0;
        @(negedge clk); bus.ld_en = 1'b0;
        chk("s5_drop", K'(bus.ld_drop), K'(1));
        @(negedge clk);
        chk("s5_drop_pulse", K'(bus.ld_drop), '0);
        wait_idle(100, n);
        @(negedge clk); bus.start = 1'b1; bus.sel = 2'd2;
        bus.ld_en = 1'b1; bus.ld_data = '0;
        @(negedge clk); bus.start = 1'b0; bus.ld_en = 1'b0;
        chk("s5_kept_ones", bus.f, '1);
        chk("s5_coinc_drop", K'(bus.ld_drop), K'(1));
        wait_idle(100, n);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
